// File: rtl/seg_scan_controller.sv
// seg_scan_controller: 4-digit multiplexed 7-segment scan driver.
// Double-buffered digits, per-slot anti-ghost blanking, registered outputs.
//
// Parameters:
//   PRESCALE     clock cycles per digit slot (2..65535)
//   BLANK_CYCLES blanked cycles at the start of each slot (1..PRESCALE-1)
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   load         one-cycle strobe, digits_in valid
//   digits_in    four BCD codes, [3:0] = digit0 (rightmost)
//   an           anode enables, active-low, one-hot-low or all-high
//   seg          segments gfedcba, active-low
//   frame_start  pulse on the first output cycle of the digit-0 slot
//   upd_pending  a loaded value waits for the next frame boundary
// Build option:
//   SEG_SCAN_LZB_EN  when defined, enables leading-zero blanking
module seg_scan_controller #(
    parameter int PRESCALE     = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_start,
    output logic        upd_pending
);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    localparam logic [15:0] SLOT_LAST = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_N   = 16'(BLANK_CYCLES);

    state_t      r_state;
    logic [15:0] r_slot_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_disp;
    logic [15:0] r_pend;
    logic        r_pending;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_frame_start;

    logic        w_wrap;
    logic        w_boundary;
    logic [15:0] w_slot_nxt;
    logic [3:0]  w_digit;
    logic [6:0]  w_dec;
    logic        w_lead;

    assign w_wrap     = (r_slot_cnt == SLOT_LAST);
    assign w_boundary = w_wrap && (r_idx == 2'd3);
    assign w_slot_nxt = w_wrap ? 16'd0 : r_slot_cnt + 16'd1;

    always_comb begin
        w_digit = r_disp[3:0];
        case (r_idx)
            2'd0: w_digit = r_disp[3:0];
            2'd1: w_digit = r_disp[7:4];
            2'd2: w_digit = r_disp[11:8];
            2'd3: w_digit = r_disp[15:12];
            default: w_digit = r_disp[3:0];
        endcase
    end

    always_comb begin
        w_dec = 7'b1111111;
        case (w_digit)
            4'd0: w_dec = 7'b1000000;
            4'd1: w_dec = 7'b1111001;
            4'd2: w_dec = 7'b0100100;
            4'd3: w_dec = 7'b0110000;
            4'd4: w_dec = 7'b0011001;
            4'd5: w_dec = 7'b0010010;
            4'd6: w_dec = 7'b0000010;
            4'd7: w_dec = 7'b1111000;
            4'd8: w_dec = 7'b0000000;
            4'd9: w_dec = 7'b0010000;
            default: w_dec = 7'b1111111;
        endcase
    end

    // A digit is a leading zero when it and every higher digit are zero;
    // digit0 always shows so a zero value still reads "0".
`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        w_lead = 1'b0;
        case (r_idx)
            2'd3: w_lead = (r_disp[15:12] == 4'd0);
            2'd2: w_lead = (r_disp[15:8] == 8'd0);
            2'd1: w_lead = (r_disp[15:4] == 12'd0);
            default: w_lead = 1'b0;
        endcase
    end
`else
    assign w_lead = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BLANK;
            r_slot_cnt    <= 16'd0;
            r_idx         <= 2'd0;
            r_disp        <= 16'h0000;
            r_pend        <= 16'h0000;
            r_pending     <= 1'b0;
            r_an          <= 4'b1111;
            r_seg         <= 7'b1111111;
            r_frame_start <= 1'b0;
        end else begin
            r_slot_cnt <= w_slot_nxt;
            if (w_wrap) begin
                r_idx <= r_idx + 2'd1;
            end
            // State tracks the counter value it will sit beside next cycle.
            r_state <= (w_slot_nxt < BLANK_N) ? ST_BLANK : ST_DRIVE;

            if (r_state == ST_DRIVE) begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_lead ? 7'b1111111 : w_dec;
            end else begin
                r_an  <= 4'b1111;
                r_seg <= 7'b1111111;
            end
            r_frame_start <= (r_slot_cnt == 16'd0) && (r_idx == 2'd0);

            // The display only changes on the frame boundary; a load on
            // that same cycle bypasses the pending buffer.
            if (w_boundary) begin
                if (load) begin
                    r_disp <= digits_in;
                end else if (r_pending) begin
                    r_disp <= r_pend;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pend    <= digits_in;
                r_pending <= 1'b1;
            end
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign frame_start = r_frame_start;
    assign upd_pending = r_pending;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: randomized self-checking bench for
// seg_scan_controller against a frame-level reference model.
module tb_seg_scan_controller;

    localparam int P  = 8;
    localparam int B  = 2;
    localparam int FR = 4 * P;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;
    logic        upd_pending;

    int n_checks;
    int n_errors;
    int cur_t;

    // Per-frame model: last value loaded in the frame and first load time.
    logic [15:0] m_ld    [0:63];
    bit          m_has   [0:63];
    int          m_first [0:63];

    seg_scan_controller #(
        .PRESCALE(P),
        .BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .digits_in(digits_in),
        .an(an),
        .seg(seg),
        .frame_start(frame_start),
        .upd_pending(upd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, cur_t, got, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] disp_of(input int f);
        logic [15:0] v;
        v = 16'h0000;
        for (int g = 0; g < f; g++) begin
            if (m_has[g]) v = m_ld[g];
        end
        return v;
    endfunction

    function automatic logic [6:0] exp_seg(input int u);
        int          i;
        logic [15:0] d;
        logic [3:0]  nib;
        if (u % P < B) return 7'b1111111;
        i   = (u / P) % 4;
        d   = disp_of(u / FR);
        nib = d[i*4 +: 4];
`ifdef SEG_SCAN_LZB_EN
        if (i > 0 && (d >> (i * 4)) == 16'h0000) return 7'b1111111;
`endif
        return dec(nib);
    endfunction

    function automatic logic [3:0] exp_an(input int u);
        logic [3:0] a;
        if (u % P < B) return 4'b1111;
        a = 4'b1111;
        a[(u / P) % 4] = 1'b0;
        return a;
    endfunction

    function automatic logic [15:0] rnd_digits();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 3) == 0) v[k*4 +: 4] = 4'd0;
            else v[k*4 +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int g = 0; g < 64; g++) begin
            m_ld[g]    = 16'h0000;
            m_has[g]   = 1'b0;
            m_first[g] = -1;
        end
    endtask

    task automatic model_load(input int t, input logic [15:0] v);
        int f;
        f = t / FR;
        m_ld[f]  = v;
        m_has[f] = 1'b1;
        if (m_first[f] < 0) m_first[f] = t;
    endtask

    // Counter value t is live between edge t and edge t+1 after release;
    // outputs seen during it describe counter value t-1.
    task automatic run_phase(input int ncyc, input int mode);
        int          f;
        bit          pend;
        bit          do_ld;
        logic [15:0] v;
        for (int t = 0; t < ncyc; t++) begin
            if (t > 0) @(negedge clk);
            cur_t = t;
            if (t == 0) begin
                chk("an_rel", 16'(an), 16'h000F);
                chk("seg_rel", 16'(seg), 16'h007F);
                chk("fs_rel", 16'(frame_start), 16'h0000);
            end else begin
                chk("an", 16'(an), 16'(exp_an(t - 1)));
                chk("seg", 16'(seg), 16'(exp_seg(t - 1)));
                chk("fs", 16'(frame_start), 16'(((t - 1) % FR) == 0));
            end
            f    = t / FR;
            pend = (m_first[f] >= 0) && (m_first[f] < t);
            chk("pend", 16'(upd_pending), 16'(pend));

            do_ld = 1'b0;
            v     = 16'h0000;
            if (mode == 0) begin
                case (t)
                    10:  begin do_ld = 1'b1; v = 16'h4321; end
                    70:  begin do_ld = 1'b1; v = 16'h1111; end
                    80:  begin do_ld = 1'b1; v = 16'h5555; end
                    159: begin do_ld = 1'b1; v = 16'h00A7; end
                    200: begin do_ld = 1'b1; v = 16'h0042; end
                    default: begin
                        if (t >= 256) begin
                            if ((t % FR) == FR - 1) begin
                                do_ld = ($urandom_range(0, 1) == 1);
                            end else begin
                                do_ld = ($urandom_range(0, 11) == 0);
                            end
                            v = rnd_digits();
                        end
                    end
                endcase
            end else if (mode == 1) begin
                if (t == 66) begin
                    do_ld = 1'b1;
                    v     = 16'h9876;
                end
            end
            if (do_ld) model_load(t, v);
            load      = do_ld;
            digits_in = v;
        end
        @(negedge clk);
        load      = 1'b0;
        digits_in = 16'h0000;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cur_t     = 0;
        rst       = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0000;
        model_clear();
        repeat (3) @(negedge clk);
        chk("an_rst", 16'(an), 16'h000F);
        chk("seg_rst", 16'(seg), 16'h007F);
        chk("fs_rst", 16'(frame_start), 16'h0000);
        chk("pend_rst", 16'(upd_pending), 16'h0000);
        rst = 1'b0;
        run_phase(512, 0);

        // Reset at digit-2 slot while an update is pending.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        run_phase(83, 1);
        #2;
        rst = 1'b1;
        #1;
        cur_t = -1;
        chk("an_async", 16'(an), 16'h000F);
        chk("seg_async", 16'(seg), 16'h007F);
        chk("fs_async", 16'(frame_start), 16'h0000);
        chk("pend_async", 16'(upd_pending), 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        run_phase(96, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter PRESCALE, default 8: clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter BLANK_CYCLES, default 2: anti-ghost blank cycles at the start of each slot; legal range 1..PRESCALE-1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  one-cycle strobe; digits_in is valid this cycle.
REQ-006 digits_in  input  16  four 4-bit digit codes; [3:0]=digit0 (rightmost) .. [15:12]=digit3.
REQ-007 an  output  4  anode enables, active-low, one-hot-low or all-high; an[i] drives digit i.
REQ-008 seg  output  7  segments gfedcba, active-low.
REQ-009 frame_start  output  1  one-cycle pulse on the first cycle of digit-0 slot.
REQ-010 upd_pending  output  1  high while a loaded value awaits its frame boundary.

Function
REQ-011 Prescaler slot_cnt SHALL count 0..PRESCALE-1 and wrap to 0; the wrap cycle ends the slot.
REQ-012 FSM SHALL have two states: BLANK (slot_cnt < BLANK_CYCLES) and DRIVE (slot_cnt >= BLANK_CYCLES).
REQ-013 BLANK SHALL drive an=4'b1111, seg=7'b1111111.
REQ-014 DRIVE SHALL drive an low only on bit idx and seg = decode of display digit idx.
REQ-015 Digit index idx SHALL advance 0->1->2->3->0 on each slot wrap; full frame = 4*PRESCALE cycles.
REQ-016 an, seg and frame_start SHALL be registered: each reflects state/counter values from the previous cycle (one-cycle latency).
REQ-017 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10..15 = 1111111.
REQ-018 load SHALL capture digits_in into a pending register and set upd_pending.
REQ-019 Further load while pending SHALL overwrite the pending value; last write wins.
REQ-020 Frame boundary = cycle where idx=3 and slot_cnt=PRESCALE-1; the display register SHALL copy pending there and upd_pending SHALL clear.
REQ-021 load coincident with the frame boundary SHALL apply digits_in directly to the display register at that boundary; upd_pending SHALL stay low.
REQ-022 Display register SHALL never change except at a frame boundary (no mid-frame tearing).
REQ-023 frame_start SHALL assert exactly once per frame, in the first cycle the pipeline outputs the digit-0 slot.

Reset
REQ-024 rst SHALL asynchronously force slot_cnt=0, idx=0, state=BLANK, display and pending registers=16'h0000, upd_pending=0.
REQ-025 During reset: an=4'b1111, seg=7'b1111111, frame_start=0.
REQ-026 Reset asserted mid-frame or while pending SHALL discard the pending value; after release, the first output cycle SHALL be the digit-0 BLANK slot.

Configuration
REQ-027 Macro SEG_SCAN_LZB_EN: when defined, leading-zero blanking is enabled: within DRIVE, digit i (i=3..1) SHALL be blanked (seg=1111111, an still asserted) if it and all higher digits are 0; digit0 is never blanked.
REQ-028 Without SEG_SCAN_LZB_EN, every digit SHALL display per REQ-017, including leading zeros.

Verification (PRESCALE=8, BLANK_CYCLES=2)
REQ-029 Reset release, no load -> per slot: 2 cycles an=1111, then 6 cycles an=1110/1101/1011/0111 in turn with seg=1000000; frame_start every 32 cycles.
REQ-030 load digits_in=16'h4321 mid-frame -> upd_pending=1 until boundary; next frame shows digit0=1111001, digit1=0100100, digit2=0110000, digit3=0011001; previous frame unchanged.
REQ-031 load 16'h1111 then 16'h5555 in same frame -> next frame shows 0010010 on all digits; 1111001 never appears.
REQ-032 load 16'h00A7 on the boundary cycle -> next frame digit0=1111000, digit1=1111111, upd_pending never high.
REQ-033 SEG_SCAN_LZB_EN defined, display 16'h0042 -> digits 3,2 seg=1111111, digit1=0011001, digit0=0100100; undefined -> digits 3,2 seg=1000000.
REQ-034 rst asserted at idx=2 with upd_pending=1 -> an=1111 immediately, upd_pending=0; after release display 0000 starting at digit 0.
